hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It holds the core idle until start and detects load-use hazards, inserting one bubble by forcing the flush opcode 6'b111111 into Control. It flushes IF/ID on taken beq and on j, and freezes the whole pipeline while data memory is busy. It sits beside Control in ID, and its write enables and PC select drive the PC, IF/ID and downstream pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared decode constants for Control and the hazard controller: opcodes, mux8 bit
// positions, FSM state and PC-select encodings.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    // Control decodes this as an instruction that writes nothing.
    localparam logic [5:0] BUBBLE_OP = 6'b111111;

    // Bit positions inside the ID/EX control bundle (mux8).
    localparam int unsigned MEMREAD  = 4;
    localparam int unsigned MEMWRITE = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StLdStall = 2'd2,
        StMemWait = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PcPlus4  = 2'b00,
        PcBranch = 2'b01,
        PcJump   = 2'b10
    } pc_src_e;

    // Opcodes whose rt field is a source operand.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signals between the ID-stage decode/pipeline and the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start_i;
    logic [5:0]       ifid_op_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_eq_i;
    logic             mem_stall_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             pipe_write_o;
    logic [5:0]       ctrl_op_o;
    logic [1:0]       pc_src_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, ifid_op_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
               branch_eq_i, mem_stall_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, pipe_write_o, ctrl_op_o, pc_src_o,
               state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, ifid_op_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
               branch_eq_i, mem_stall_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, pipe_write_o, ctrl_op_o, pc_src_o,
               state_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: idle hold, load-use bubble, branch/jump flush and memory-busy freeze.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    state_e  r_state;
    state_e  w_state_d;
    logic    w_luh;
    logic    w_taken;
    logic    w_jump;
    logic    w_stall_inc;
    logic    w_flush_inc;
    logic    w_pc_write;
    logic    w_ifid_write;
    logic    w_ifid_flush;
    logic    w_pipe_write;
    logic [5:0] w_ctrl_op;
    pc_src_e w_pc_src;

    assign w_luh = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) ||
                    ((bus.idex_rt_i == bus.ifid_rt_i) && reads_rt(bus.ifid_op_i)));
    assign w_taken = (bus.ifid_op_i == OP_BEQ) && bus.branch_eq_i;
    assign w_jump  = (bus.ifid_op_i == OP_J);

    // All non-idle states resolve identically; the state only records why we got there.
    always_comb begin
        w_state_d    = r_state;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_pipe_write = 1'b1;
        w_ctrl_op    = bus.ifid_op_i;
        w_pc_src     = PcPlus4;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_ifid_flush = 1'b1;
                w_ctrl_op    = BUBBLE_OP;
                if (bus.start_i) begin
                    w_state_d = StRun;
                end
            end
            default: begin
                if (bus.mem_stall_i) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_pipe_write = 1'b0;
                    w_stall_inc  = 1'b1;
                    w_state_d    = StMemWait;
                end else if (w_luh) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_ctrl_op    = BUBBLE_OP;
                    w_stall_inc  = 1'b1;
                    w_state_d    = StLdStall;
                end else begin
                    w_state_d = StRun;
                    if (w_taken || w_jump) begin
                        w_ifid_flush = 1'b1;
                        w_pc_src     = w_jump ? PcJump : PcBranch;
                        w_flush_inc  = 1'b1;
                    end
                end
                if (!bus.start_i) begin
                    w_state_d   = StIdle;
                    w_stall_inc = 1'b0;
                    w_flush_inc = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_stall_inc),
        .count_o (bus.stall_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_flush_inc),
        .count_o (bus.flush_cnt_o)
    );

    assign bus.pc_write_o   = w_pc_write;
    assign bus.ifid_write_o = w_ifid_write;
    assign bus.ifid_flush_o = w_ifid_flush;
    assign bus.pipe_write_o = w_pipe_write;
    assign bus.ctrl_op_o    = w_ctrl_op;
    assign bus.pc_src_o     = w_pc_src;
    assign bus.state_o      = r_state;

endmodule
